puneh_exec_unit: RTL and testbench
==================================

# puneh_exec_unit

Parametrised execution unit for the PUNEH datapath family.
- Replaces the single-cycle combinational arithmetic unit with a handshaked unit: single-cycle ADD/SUB and an iterative shift-add unsigned multiplier with a full double-width product.
- Owns the Z/N/C/V status register with per-flag load mask and the conditional-skip evaluation.
- The controller starts an operation, waits for `done`, then loads the accumulator from `res`.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width (≥4)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  operation request, sampled only in IDLE
- `op`  in  2  00 ADD, 01 SUB, 10 MUL, 11 reserved (treated as ADD)
- `in0`, `in1`  in  WIDTH  operands, latched on the accepting edge
- `flag_mask`  in  4  flags to update on completion {Z,N,C,V}, latched with operands
- `abort`  in  1  synchronous cancel of a running MUL
- `exp`  in  4  expected flag values for skip test
- `obs`  in  4  flags observed by skip test
- `busy`  out  1  MUL in progress
- `done`  out  1  one-cycle completion pulse
- `res`  out  WIDTH  result (low half of product for MUL)
- `res_hi`  out  WIDTH  high half of product; 0 after ADD/SUB
- `flags`  out  4  {Z,N,C,V} registered status
- `en_skp`  out  1  combinational skip enable

## Operation
States:
- **IDLE**
  - `start`=1 with ADD/SUB: compute, stay IDLE, pulse `done`.
  - `start`=1 with MUL: latch operands, go RUN, count=0.
- **RUN**
  - Each cycle: if multiplier LSB is 1, add multiplicand to the partial high half; shift {hi,lo} right one bit; count++.
  - Final iteration at count=WIDTH-1 → back to IDLE with `done`.

Arithmetic (all in WIDTH bits, carry from the WIDTH+1-bit sum):
- ADD: res=in0+in1. C=carry out. V=signed overflow (operand signs equal, result sign differs).
- SUB: res=in0+~in1+1. C=carry out (1 = no borrow). V=signed overflow of subtraction.
- MUL: unsigned, {res_hi,res}=in0*in1. C=(res_hi≠0). V=0.
- All ops: Z=({res_hi,res}==0). N=res[WIDTH-1].

Flag update:
- Bit i of `flags` loads only on the completion edge, and only if latched `flag_mask[i]`=1.
- Otherwise bit i holds its value.

Skip:
- en_skp = OR over i of obs[i] & (flags[i] ~^ exp[i]).
- obs=0 gives en_skp=0.

Boundaries:
- `start` while `busy`: ignored, no queueing.
- `abort` in RUN: back to IDLE next edge. No `done`. res/res_hi/flags unchanged. abort in IDLE: no effect. abort together with start in IDLE: start wins.
- Operands changing during RUN have no effect, since they are latched.
- Reset mid-RUN: immediate return to IDLE, all outputs to reset values.

## Timing
- Reset values: busy=0, done=0, res=0, res_hi=0, flags=0000, state IDLE.
- E0 is the edge that samples `start`.
- ADD/SUB: res/res_hi/flags updated at E0. done=1 during the cycle after E0. busy stays 0.
- MUL: busy=1 from E0 until E_WIDTH. Iterations occur at E1..E_WIDTH. At E_WIDTH: res/res_hi/flags update, busy=0, done=1 for one cycle.
- Latency: ADD/SUB 1 cycle; MUL WIDTH cycles.
- Back-to-back:
  - A new `start` is accepted in the same cycle `done` is high, since the state is IDLE.
  - ADD/SUB every cycle gives `done` every cycle.
- en_skp has zero latency from flags/exp/obs.

## Structure
- Shared package `puneh_pkg`:
  - op encodings `OP_ADD`/`OP_SUB`/`OP_MUL`
  - flag indices `FLG_Z`=3, `FLG_N`=2, `FLG_C`=1, `FLG_V`=0
  - FSM state type (IDLE, RUN)
- Sub-module `puneh_seq_mul`:
  - shift-add core with multiplicand/partial/count registers
  - `go`/`abort`/`fin` signals
- Top holds the FSM, ADD/SUB logic, flag register and skip logic.

## Test plan
- Reset: assert rst=0 mid-operation → all outputs 0 immediately. After release, busy=0 and flags=0000.
- ADD, WIDTH=16: 0x7FFF+0x0001, mask=1111 → res=0x8000, flags Z0 N1 C0 V1, done one cycle after start, busy never high.
- SUB: 0x0005−0x0005, mask=1000 → res=0. Only Z set to 1; N/C/V hold their prior values.
- MUL: 0xFFFF*0xFFFF → busy for 16 cycles, done at E16, {res_hi,res}=0xFFFE_0001, flags Z0 N0 C1 V0. A start issued at E5 is ignored.
- Abort: MUL 3*4, abort at E3 → IDLE at E4, no done pulse, res unchanged. A fresh MUL 3*4 then gives res=12, res_hi=0, done at E16.
- Skip: flags=1010, obs=0100, exp=0000 → en_skp=1; exp=0100 → en_skp=0; obs=0000 → 0.

Source files
------------

// File: rtl/puneh_pkg.sv
// Shared definitions for the PUNEH execution unit: opcodes, flag bit
// positions, the controller state type and small flag helpers.
package puneh_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Assemble a flag vector so the bit positions always follow FLG_*.
  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_Z] = z;
    f[FLG_N] = n;
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

  // Bits selected by mask take the new value, the rest keep the old one.
  function automatic logic [3:0] flag_merge(input logic [3:0] old_f,
                                            input logic [3:0] new_f,
                                            input logic [3:0] mask);
    return (old_f & ~mask) | (new_f & mask);
  endfunction

endpackage

// File: rtl/puneh_exec_unit_if.sv
// Controller-facing bundle of the PUNEH execution unit.
//
// Handshake: start is a request sampled only while the unit is IDLE
// (busy=0); there is no ready and no queueing, so a start seen while busy
// is dropped. done is a single-cycle pulse, and res/res_hi/flags are
// already valid in the cycle done is high. A new start may be presented
// in the same cycle done is high.
interface puneh_exec_unit_if #(
  parameter int WIDTH = 16
);
  import puneh_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [3:0]       flag_mask;
  logic             abort;
  logic [3:0]       exp;
  logic [3:0]       obs;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic [3:0]       flags;
  logic             en_skp;
  state_t           dbg_state;

  modport master (
    output start, op, in0, in1, flag_mask, abort, exp, obs,
    input  busy, done, res, res_hi, flags, en_skp, dbg_state
  );

  modport slave (
    input  start, op, in0, in1, flag_mask, abort, exp, obs,
    output busy, done, res, res_hi, flags, en_skp, dbg_state
  );

endinterface

// File: rtl/puneh_seq_mul.sv
// Iterative shift-add unsigned multiplier. go loads the operands; each
// following cycle performs one iteration. fin marks the edge on which the
// last iteration happens, and prod_hi_o/prod_lo_o carry the value the
// product registers take on that edge.
module puneh_seq_mul
  import puneh_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             fin_o,
  output logic [WIDTH-1:0] prod_hi_o,
  output logic [WIDTH-1:0] prod_lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             last;

  // One iteration: conditional add into the high half, then shift the
  // whole {carry,hi,lo} right so the multiplier bits drain out of lo.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], lo_q[WIDTH-1:1]};
    last    = (cnt_q == LAST);
    fin_o   = active_q & ~abort_i & last;
  end

  assign prod_hi_o = step_hi;
  assign prod_lo_o = step_lo;

  // Next-state of the multiplier registers: load, iterate or cancel.
  always_comb begin
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (go_i) begin
      mcand_d  = a_i;
      lo_d     = b_i;
      hi_d     = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (abort_i) begin
        active_d = 1'b0;
      end else begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (last) active_d = 1'b0;
      end
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/puneh_exec_unit.sv
// PUNEH execution unit: single-cycle ADD/SUB, iterative MUL through
// puneh_seq_mul, the Z/N/C/V status register with per-flag load mask and
// the combinational conditional-skip test.
module puneh_exec_unit
  import puneh_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  puneh_exec_unit_if.slave   bus
);

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic [3:0]       mask_q, mask_d;

  logic             mul_go;
  logic             mul_abort;
  logic             mul_fin;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [3:0]       mul_flags;

  logic             is_sub;
  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH:0]   as_sum;
  logic [WIDTH-1:0] as_res;
  logic [3:0]       as_flags;

  // ADD/SUB datapath; SUB is in0 + ~in1 + 1 so carry means "no borrow".
  always_comb begin
    is_sub   = (bus.op == OP_SUB);
    b_opnd   = is_sub ? ~bus.in1 : bus.in1;
    as_sum   = {1'b0, bus.in0} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, is_sub};
    as_res   = as_sum[WIDTH-1:0];
    as_flags = pack_flags(as_res == '0,
                          as_res[WIDTH-1],
                          as_sum[WIDTH],
                          (bus.in0[WIDTH-1] == b_opnd[WIDTH-1]) &&
                          (as_res[WIDTH-1] != bus.in0[WIDTH-1]));
  end

  assign mul_abort = (state_q == ST_RUN) & bus.abort;

  puneh_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .go_i     (mul_go),
    .abort_i  (mul_abort),
    .a_i      (bus.in0),
    .b_i      (bus.in1),
    .fin_o    (mul_fin),
    .prod_hi_o(mul_hi),
    .prod_lo_o(mul_lo)
  );

  // Flags of the finished product: carry reports a non-zero high half.
  always_comb begin
    mul_flags = pack_flags({mul_hi, mul_lo} == '0, mul_lo[WIDTH-1],
                           mul_hi != '0, 1'b0);
  end

  // Controller: next state and the result/flag register updates.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    flags_d  = flags_q;
    mask_d   = mask_q;
    mul_go   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            mul_go  = 1'b1;
            mask_d  = bus.flag_mask;
            state_d = ST_RUN;
          end else begin
            res_d    = as_res;
            res_hi_d = '0;
            flags_d  = flag_merge(flags_q, as_flags, bus.flag_mask);
            done_d   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (mul_fin) begin
          state_d  = ST_IDLE;
          res_d    = mul_lo;
          res_hi_d = mul_hi;
          flags_d  = flag_merge(flags_q, mul_flags, mask_q);
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
      mask_q   <= mask_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = done_q;
  assign bus.res       = res_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.flags     = flags_q;
  assign bus.dbg_state = state_q;
  // Skip when any observed flag matches its expected value.
  assign bus.en_skp    = |(bus.obs & ~(flags_q ^ bus.exp));

endmodule

// File: tb/tb_puneh_exec_unit.sv
// Bench for puneh_exec_unit: directed corner cases plus randomized
// operations, checked by a scoreboard against an arithmetic reference.
module tb_puneh_exec_unit;
  import puneh_pkg::*;

  localparam int W  = 16;
  localparam int EW = 32 + 2*W + 4;
  localparam longint MOD  = longint'(1) << W;
  localparam longint SMAX = (longint'(1) << (W-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W-1));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  puneh_exec_unit_if #(.WIDTH(W)) bus();
  puneh_exec_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [3:0]    m_flags = '0;
  logic [W-1:0]  m_res   = '0;
  logic [W-1:0]  m_hi    = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] m);
    longint ua, ub, sa, sb, r;
    logic [W-1:0] lo, hi;
    logic z, n, c, v;
    logic [3:0] nf;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - MOD : ua;
    sb = b[W-1] ? ub - MOD : ub;
    if (o == OP_MUL) begin
      r  = ua * ub;
      lo = W'(r);
      hi = W'(r / MOD);
      c  = (hi != 0);
      v  = 1'b0;
    end else if (o == OP_SUB) begin
      r  = ua - ub;
      lo = W'(r);
      hi = '0;
      c  = (ua >= ub);
      v  = ((sa - sb) > SMAX) || ((sa - sb) < SMIN);
    end else begin
      r  = ua + ub;
      lo = W'(r);
      hi = '0;
      c  = (r >= MOD);
      v  = ((sa + sb) > SMAX) || ((sa + sb) < SMIN);
    end
    z  = (lo == 0) && (hi == 0);
    n  = lo[W-1];
    nf = {z, n, c, v};
    for (int i = 0; i < 4; i++) if (m[i]) m_flags[i] = nf[i];
    m_res = lo;
    m_hi  = hi;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
        check("res_hi", bus.res_hi, e[2*W+3 -: W]);
        check("res", bus.res, e[W+3 -: W]);
        check("flags", bus.flags, e[3:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one request for the accepting edge E0, returns at E0+#1.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] m, input bit keep);
    bus.op = o; bus.in0 = a; bus.in1 = b; bus.flag_mask = m; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, (o == OP_MUL));
    if (keep) begin
      model_op(o, a, b, m);
      exp_q.push_back({32'(cyc + ((o == OP_MUL) ? W : 0)), m_hi, m_res, m_flags});
    end
  endtask

  // Full MUL; a stray ADD start with fresh operands is thrown at E_intr.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] m,
                         input int intr);
    int n;
    issue(OP_MUL, a, b, m, 1'b1);
    n = 0;
    for (int k = 1; k <= W + 3 && bus.busy; k++) begin
      if (k == intr) begin
        bus.start = 1'b1; bus.op = OP_ADD;
        bus.in0 = W'($urandom); bus.in1 = W'($urandom); bus.flag_mask = 4'hF;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n = k;
    end
    check("mul_busy_cycles", 64'(n), 64'(W));
  endtask

  // MUL cancelled by abort asserted after E_k (sampled at E_k+1).
  task automatic abort_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] m,
                           input int k);
    issue(OP_MUL, a, b, m, 1'b0);
    repeat (k) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_res", bus.res, m_res);
    check("abort_res_hi", bus.res_hi, m_hi);
    check("abort_flags", bus.flags, m_flags);
    repeat (W) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 3 * W && (exp_q.size() != 0 || bus.busy); k++) @(negedge clk);
    @(negedge clk);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_skip(input logic [3:0] e, input logic [3:0] o);
    bit s;
    bus.exp = e; bus.obs = o;
    #1;
    s = 1'b0;
    for (int i = 0; i < 4; i++) if (o[i] && (m_flags[i] == e[i])) s = 1'b1;
    check("en_skp", bus.en_skp, s);
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    logic [W-1:0] corners [5];
    corners[0] = '0; corners[1] = W'(1); corners[2] = W'(16'h7FFF);
    corners[3] = W'(16'h8000); corners[4] = '1;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bus.start = 1'b0; bus.op = OP_ADD; bus.in0 = '0; bus.in1 = '0;
    bus.flag_mask = '0; bus.abort = 1'b0; bus.exp = '0; bus.obs = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_res", bus.res, 0);
    check("rst_res_hi", bus.res_hi, 0);
    check("rst_flags", bus.flags, 4'b0000);
    check("rst_state", bus.dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed corners.
    issue(OP_ADD, 16'h7FFF, 16'h0001, 4'b1111, 1'b1);
    drain();
    issue(OP_SUB, 16'h0005, 16'h0005, 4'b1000, 1'b1);
    drain();
    run_mul(16'hFFFF, 16'hFFFF, 4'b1111, 5);
    drain();
    abort_mul(16'd3, 16'd4, 4'b1111, 3);
    run_mul(16'd3, 16'd4, 4'b1111, 0);
    drain();
    issue(OP_SUB, 16'h0000, 16'h0000, 4'b1111, 1'b1);  // flags 1010
    drain();
    check_skip(4'b0000, 4'b0100);
    check_skip(4'b0100, 4'b0100);
    check_skip(4'b0000, 4'b0000);
    // abort while idle has no effect; back-to-back ADDs
    bus.abort = 1'b1;
    issue(OP_ADD, 16'h1234, 16'h4321, 4'b0110, 1'b1);
    bus.abort = 1'b0;
    for (int i = 0; i < 4; i++) issue(OP_ADD, rnd_opnd(), rnd_opnd(), 4'(i * 5), 1'b1);
    drain();

    // Randomized operations.
    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        issue(OP_ADD, rnd_opnd(), rnd_opnd(), 4'($urandom), 1'b1);
      end else if (sel <= 5) begin
        issue(OP_SUB, rnd_opnd(), rnd_opnd(), 4'($urandom), 1'b1);
      end else if (sel == 6) begin
        issue(2'b11, rnd_opnd(), rnd_opnd(), 4'($urandom), 1'b1);
      end else if (sel <= 8) begin
        run_mul(rnd_opnd(), rnd_opnd(), 4'($urandom),
                ($urandom_range(0, 1) == 1) ? $urandom_range(1, W - 1) : 0);
      end else begin
        drain();
        abort_mul(rnd_opnd(), rnd_opnd(), 4'($urandom), $urandom_range(1, W - 2));
      end
      if ($urandom_range(0, 2) == 0) begin
        drain();
        check_skip(4'($urandom), 4'($urandom));
      end
    end
    drain();

    // Reset in the middle of a MUL.
    issue(OP_MUL, 16'hABCD, 16'h1357, 4'b1111, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    m_flags = '0; m_res = '0; m_hi = '0;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_res", bus.res, 0);
    check("midrst_res_hi", bus.res_hi, 0);
    check("midrst_flags", bus.flags, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_flags", bus.flags, 4'b0000);
    run_mul(16'd3, 16'd4, 4'b1111, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
